// File: rtl/fibo_datapath.sv
// fibo_datapath: four-entry register file feeding an eight-operation ALU,
// with a registered result (alu_out) and registered zero flag for a controller.
// Optional feature: define FIBO_DP_OVF_EN to add the registered ovf_flag output
// (carry-out for add/increment, borrow for subtract/decrement).
module fibo_datapath #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [SIZE-2:0]  wrt_addr,
  input  logic             wrt_en,
  input  logic             load_data,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SIZE-2:0]  rd_addr1,
  input  logic [SIZE-2:0]  rd_addr2,
  input  logic [SIZE-1:0]  alu_opcode,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero_flag
`ifdef FIBO_DP_OVF_EN
  ,
  output logic             ovf_flag
`endif
);

  localparam int NREGS = 2 ** (SIZE - 1);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [SIZE-1:0] OP_PASS = SIZE'(0);
  localparam logic [SIZE-1:0] OP_ADD  = SIZE'(1);
  localparam logic [SIZE-1:0] OP_SUB  = SIZE'(2);
  localparam logic [SIZE-1:0] OP_AND  = SIZE'(3);
  localparam logic [SIZE-1:0] OP_OR   = SIZE'(4);
  localparam logic [SIZE-1:0] OP_XOR  = SIZE'(5);
  localparam logic [SIZE-1:0] OP_INC  = SIZE'(6);
  localparam logic [SIZE-1:0] OP_DEC  = SIZE'(7);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_alu_result;
  logic [WIDTH-1:0] w_wr_data;

  // Both read ports are plain muxes on the stored values: a write in this
  // cycle is not bypassed, so readers see the old contents until the next edge.
  assign w_op_a    = r_regs[rd_addr1];
  assign w_op_b    = r_regs[rd_addr2];
  assign w_wr_data = load_data ? data_in : w_alu_result;

  // ALU: combinational, arithmetic wraps modulo 2^WIDTH by truncation.
  always_comb begin
    w_alu_result = '0;
    case (alu_opcode)
      OP_PASS: w_alu_result = w_op_a;
      OP_ADD:  w_alu_result = w_op_a + w_op_b;
      OP_SUB:  w_alu_result = w_op_a - w_op_b;
      OP_AND:  w_alu_result = w_op_a & w_op_b;
      OP_OR:   w_alu_result = w_op_a | w_op_b;
      OP_XOR:  w_alu_result = w_op_a ^ w_op_b;
      OP_INC:  w_alu_result = w_op_a + ONE;
      OP_DEC:  w_alu_result = w_op_a - ONE;
      default: w_alu_result = '0;
    endcase
  end

  // Register file: reset clears every entry and overrides any pending write.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wrt_en) begin
      r_regs[wrt_addr] <= w_wr_data;
    end
  end

  // Result/zero flag register: captures the ALU every cycle, same edge as any write-back.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      alu_out   <= '0;
      zero_flag <= 1'b0;
    end else begin
      alu_out   <= w_alu_result;
      zero_flag <= (w_alu_result == '0);
    end
  end

`ifdef FIBO_DP_OVF_EN
  logic w_ovf;

  // Carry/borrow derived from operands: a truncated sum smaller than an
  // operand means it wrapped; a borrow happens when the subtrahend is larger.
  always_comb begin
    w_ovf = 1'b0;
    case (alu_opcode)
      OP_ADD:  w_ovf = (w_alu_result < w_op_a);
      OP_SUB:  w_ovf = (w_op_a < w_op_b);
      OP_INC:  w_ovf = (w_op_a == '1);
      OP_DEC:  w_ovf = (w_op_a == '0);
      default: w_ovf = 1'b0;
    endcase
  end

  // Overflow flag register, kept in step with alu_out/zero_flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ovf_flag <= 1'b0;
    end else begin
      ovf_flag <= w_ovf;
    end
  end
`endif

endmodule
